// File: rtl/prescaled_mode_counter.sv
// rtl/prescaled_mode_counter.sv - prescaled up/down counter with wrap, saturate and one-shot modes
module prescaled_mode_counter #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 25000000,
    parameter int STEP     = 1
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             enable,
    input  logic             up_down,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] counter,
    output logic             tick,
    output logic             wrapped,
    output logic             at_limit,
    output logic             done,
    output logic             busy
);

    localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH:0]   STEP_X  = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] MAX     = '1;

    localparam logic [1:0] MODE_SAT  = 2'b01;
    localparam logic [1:0] MODE_ONCE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [PW-1:0]    presc_q;
    logic [WIDTH-1:0] counter_q;
    logic             tick_q;
    logic             wrapped_q;

    logic [WIDTH:0]   sum_x;
    logic [WIDTH:0]   diff_x;
    logic [WIDTH-1:0] counter_d;
    logic             wrapped_d;
    logic             finish_d;

    // One extra bit catches carry on the way up and borrow on the way down.
    assign sum_x  = {1'b0, counter_q} + STEP_X;
    assign diff_x = {1'b0, counter_q} - STEP_X;

    always_comb begin
        counter_d = counter_q;
        wrapped_d = 1'b0;
        finish_d  = 1'b0;
        if (up_down) begin
            if (sum_x[WIDTH]) begin
                case (mode)
                    MODE_SAT:  counter_d = MAX;
                    MODE_ONCE: begin
                        counter_d = MAX;
                        finish_d  = 1'b1;
                    end
                    default: begin
                        counter_d = sum_x[WIDTH-1:0];
                        wrapped_d = 1'b1;
                    end
                endcase
            end else begin
                counter_d = sum_x[WIDTH-1:0];
                finish_d  = (mode == MODE_ONCE) && (sum_x[WIDTH-1:0] == MAX);
            end
        end else begin
            if (diff_x[WIDTH]) begin
                case (mode)
                    MODE_SAT:  counter_d = '0;
                    MODE_ONCE: begin
                        counter_d = '0;
                        finish_d  = 1'b1;
                    end
                    default: begin
                        counter_d = diff_x[WIDTH-1:0];
                        wrapped_d = 1'b1;
                    end
                endcase
            end else begin
                counter_d = diff_x[WIDTH-1:0];
                finish_d  = (mode == MODE_ONCE) && (diff_x[WIDTH-1:0] == '0);
            end
        end
    end

    // Load outranks stop/start and suppresses any step landing on the same edge.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            counter_q <= '0;
            tick_q    <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            tick_q    <= 1'b0;
            wrapped_q <= 1'b0;
            if (load) begin
                counter_q <= load_value;
                presc_q   <= '0;
            end else if (stop) begin
                state_q <= S_IDLE;
                presc_q <= '0;
            end else if (start && (state_q != S_RUN)) begin
                state_q <= S_RUN;
                presc_q <= '0;
            end else if ((state_q == S_RUN) && enable) begin
                if (presc_q == PS_LAST) begin
                    presc_q   <= '0;
                    counter_q <= counter_d;
                    tick_q    <= 1'b1;
                    wrapped_q <= wrapped_d;
                    if (finish_d) begin
                        state_q <= S_DONE;
                    end
                end else begin
                    presc_q <= presc_q + PW'(1);
                end
            end
        end
    end

    assign counter  = counter_q;
    assign tick     = tick_q;
    assign wrapped  = wrapped_q;
    assign done     = (state_q == S_DONE);
    assign busy     = (state_q == S_RUN);
    assign at_limit = (up_down && (counter_q == MAX)) || (!up_down && (counter_q == '0));

endmodule

// File: tb/tb_prescaled_mode_counter.sv
// tb/tb_prescaled_mode_counter.sv - scoreboard bench for prescaled_mode_counter
module tb_prescaled_mode_counter;

    logic       clk_in = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       enable = 1'b0;
    logic       up_down = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;
    logic [3:0] counter;
    logic       tick;
    logic       wrapped;
    logic       at_limit;
    logic       done;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int c0;
    int c1;

    typedef struct {
        int cyc;
        int cnt;
        int wr;
        int dn;
        int bz;
    } exp_t;

    exp_t exp_q[$];

    prescaled_mode_counter #(
        .WIDTH(4),
        .PRESCALE(4),
        .STEP(3)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .start(start),
        .stop(stop),
        .enable(enable),
        .up_down(up_down),
        .mode(mode),
        .load(load),
        .load_value(load_value),
        .counter(counter),
        .tick(tick),
        .wrapped(wrapped),
        .at_limit(at_limit),
        .done(done),
        .busy(busy)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic push(input int c, input int cnt, input int wr, input int dn, input int bz);
        exp_t e;
        e.cyc = c;
        e.cnt = cnt;
        e.wr  = wr;
        e.dn  = dn;
        e.bz  = bz;
        exp_q.push_back(e);
    endtask

    task automatic do_load(input int v);
        load_value = 4'(v);
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic do_start(output int entry);
        start = 1'b1;
        step();
        start = 1'b0;
        entry = cyc;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (tick) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tick cyc=%0d counter=%0d expected no tick", cyc, counter);
                end else begin
                    e = exp_q.pop_front();
                    check("tick_cycle", cyc, e.cyc);
                    check("tick_counter", int'(counter), e.cnt);
                    check("tick_wrapped", int'(wrapped), e.wr);
                    check("tick_done", int'(done), e.dn);
                    check("tick_busy", int'(busy), e.bz);
                end
            end
            check("wrapped_without_tick", int'(wrapped && !tick), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        check("rst_counter", int'(counter), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_wrapped", int'(wrapped), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_at_limit_down0", int'(at_limit), 1);
        reset = 1'b1;
        enable = 1'b1;
        up_down = 1'b1;
        step();

        // basic up count, step 3
        mode = 2'b00;
        do_start(c0);
        check("run_busy", int'(busy), 1);
        push(c0 + 4, 3, 0, 0, 1);
        push(c0 + 8, 6, 0, 0, 1);
        push(c0 + 12, 9, 0, 0, 1);
        wait_until(c0 + 12);
        do_stop();
        check("stop_busy", int'(busy), 0);
        check("stop_counter", int'(counter), 9);
        repeat (8) step();
        check("stop_hold_counter", int'(counter), 9);

        // wrap up then down
        do_load(14);
        check("load_idle_counter", int'(counter), 14);
        do_start(c0);
        push(c0 + 4, 1, 1, 0, 1);
        wait_until(c0 + 4);
        up_down = 1'b0;
        push(c0 + 8, 14, 1, 0, 1);
        wait_until(c0 + 8);
        do_stop();

        // saturate
        mode = 2'b01;
        up_down = 1'b1;
        do_load(13);
        do_start(c0);
        push(c0 + 4, 15, 0, 0, 1);
        push(c0 + 8, 15, 0, 0, 1);
        wait_until(c0 + 8);
        check("sat_at_limit_up", int'(at_limit), 1);
        up_down = 1'b0;
        do_load(2);
        check("load_run_counter", int'(counter), 2);
        check("load_run_busy", int'(busy), 1);
        push(c0 + 13, 0, 0, 0, 1);
        push(c0 + 17, 0, 0, 0, 1);
        wait_until(c0 + 17);
        check("sat_at_limit_down", int'(at_limit), 1);
        do_stop();

        // one-shot: exact landing on MAX, then overflow re-entry
        mode = 2'b10;
        up_down = 1'b1;
        do_load(9);
        do_start(c0);
        push(c0 + 4, 12, 0, 0, 1);
        push(c0 + 8, 15, 0, 1, 0);
        wait_until(c0 + 8);
        repeat (80) step();
        check("once_frozen_counter", int'(counter), 15);
        check("once_done", int'(done), 1);
        check("once_busy", int'(busy), 0);
        do_start(c1);
        check("restart_busy", int'(busy), 1);
        check("restart_done", int'(done), 0);
        push(c1 + 4, 15, 0, 1, 0);
        wait_until(c1 + 4);
        do_load(5);
        check("load_done_stays", int'(done), 1);
        check("load_done_counter", int'(counter), 5);
        stop = 1'b1;
        start = 1'b1;
        step();
        stop = 1'b0;
        start = 1'b0;
        check("stop_start_done", int'(done), 0);
        check("stop_start_busy", int'(busy), 0);

        // enable gating, ignored start in RUN
        mode = 2'b00;
        do_load(0);
        do_start(c0);
        wait_until(c0 + 2);
        enable = 1'b0;
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_in_run_busy", int'(busy), 1);
        wait_until(c0 + 12);
        enable = 1'b1;
        push(c0 + 14, 3, 0, 0, 1);
        push(c0 + 18, 6, 0, 0, 1);

        // load coincident with step
        wait_until(c0 + 21);
        do_load(11);
        check("load_step_counter", int'(counter), 11);
        check("load_step_tick", int'(tick), 0);
        push(c0 + 26, 14, 0, 0, 1);

        // reset beats load and a due step
        wait_until(c0 + 29);
        reset = 1'b0;
        load_value = 4'd7;
        load = 1'b1;
        step();
        check("rst_run_counter", int'(counter), 0);
        check("rst_run_tick", int'(tick), 0);
        check("rst_run_wrapped", int'(wrapped), 0);
        check("rst_run_busy", int'(busy), 0);
        check("rst_run_done", int'(done), 0);
        reset = 1'b1;
        load = 1'b0;
        repeat (10) step();
        check("post_rst_counter", int'(counter), 0);
        check("post_rst_busy", int'(busy), 0);

        repeat (5) step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prescaled_mode_counter.md
Name: prescaled_mode_counter

Overview:
- Parametrised successor to the team's fixed 8-bit divided-clock counter.
- A prescaler divides `clk_in` by `PRESCALE` to produce single-cycle step enables.
- On each step a `WIDTH`-bit counter moves up or down by `STEP`, in wrap, saturate or one-shot mode.
- Adds start/stop control, synchronous load and status pulses; drives displays/LEDs and timeout logic in the same clock domain.

Parameters:
- `WIDTH`, 8, counter width in bits (≥2).
- `PRESCALE`, 25000000, `clk_in` cycles per step (≥1; 1 = step every cycle).
- `STEP`, 1, increment/decrement magnitude (1 ≤ `STEP` ≤ 2^`WIDTH`-1).

Ports:
- `clk_in`, input, 1, sole clock; all logic on rising edge.
- `reset`, input, 1, synchronous, active-low; clears everything on a rising edge where `reset`=0.
- `start`, input, 1, pulse: IDLE/DONE -> RUN.
- `stop`, input, 1, pulse: any state -> IDLE.
- `enable`, input, 1, level: prescaler advances only when 1 in RUN.
- `up_down`, input, 1, 1 = count up, 0 = count down; sampled at each step.
- `mode`, input, 2, 00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
- `load`, input, 1, pulse: counter <= `load_value`.
- `load_value`, input, `WIDTH`, value written on `load`.
- `counter`, output, `WIDTH`, registered count.
- `tick`, output, 1, registered one-cycle pulse on every step.
- `wrapped`, output, 1, registered one-cycle pulse when a step crosses a boundary in wrap mode.
- `at_limit`, output, 1, combinational: (`up_down`=1 and `counter`=2^`WIDTH`-1) or (`up_down`=0 and `counter`=0).
- `done`, output, 1, 1 while in DONE.
- `busy`, output, 1, 1 while in RUN.

Behaviour:
- Reset (`reset`=0 at an edge): `counter`=0, prescaler=0, state=IDLE, `tick`=0, `wrapped`=0, `done`=0, `busy`=0. Reset beats all other inputs, including mid-RUN.
- Priority per edge: reset > `load` > `stop` > `start` > step.
- States:
  - IDLE: counter holds, prescaler held at 0. `start` -> RUN.
  - RUN: prescaler active. `stop` -> IDLE. One-shot boundary reached -> DONE.
  - DONE: counter holds. `start` -> RUN. `stop` -> IDLE.
- `start` in RUN is ignored.
- Prescaler runs 0..`PRESCALE`-1 only in RUN with `enable`=1; it freezes (keeps its value) when `enable`=0.
- A step occurs on the edge where prescaler=`PRESCALE`-1 and `enable`=1. The prescaler returns to 0, and `counter` and `tick` update on that same edge.
- First step occurs exactly `PRESCALE` enabled cycles after entering RUN.
- Entering RUN from any state clears the prescaler.
- Arithmetic is done in `WIDTH`+1 bits. MAX=2^`WIDTH`-1.
  - Up, sum ≤ MAX: counter=sum.
  - Up, sum > MAX:
    - wrap: counter=sum mod 2^`WIDTH`, `wrapped` pulses.
    - saturate: counter=MAX.
    - one-shot: counter=MAX and state -> DONE on the same edge.
  - Down, `counter` ≥ `STEP`: counter=`counter`-`STEP`.
  - Down, `counter` < `STEP`:
    - wrap: counter=(`counter`-`STEP`) mod 2^`WIDTH`, `wrapped` pulses.
    - saturate: counter=0.
    - one-shot: counter=0, -> DONE.
  - One-shot also enters DONE when a step lands exactly on MAX (up) or 0 (down).
- Saturate at the limit: each further step still pulses `tick`; `counter` is unchanged.
- `load`:
  - Sets `counter`, clears prescaler, state unchanged.
  - If `load` and a step coincide, the load wins, and `tick` and `wrapped` stay 0 that cycle.
  - `load` in DONE does not leave DONE.
- `mode` and `up_down` changes take effect at the next step; no state change by themselves.
- `stop`+`start` together: `stop` wins.

Test Plan:
- Basic up count (`WIDTH`=8, `PRESCALE`=4, `STEP`=1, mode 00): reset, start, `enable`=1 -> `counter` 1,2,3 at 4,8,12 cycles after RUN entry; `tick` high exactly 1 cycle each; `busy`=1.
- Wrap (`WIDTH`=4, `STEP`=3, mode 00): load 14, start, up -> after one step `counter`=1, `wrapped`=1 for one cycle. Down from 1 -> 14, `wrapped` pulses.
- Saturate (`WIDTH`=4, `STEP`=3, mode 01): load 13, up -> 15, then 15 held with `tick` still pulsing, `at_limit`=1. Down from 2 -> 0, stays 0.
- One-shot (`WIDTH`=4, `STEP`=1, mode 10): load 13, start -> 14, 15, then `done`=1, `busy`=0, `counter` frozen at 15 over 20 more prescale periods. `start` -> RUN with prescaler cleared; next step gives 15 again and re-enters DONE.
- `enable` gating and `stop`: `PRESCALE`=4, drop `enable` after 2 prescale cycles for 10 cycles -> step delayed by exactly 10 cycles. `stop` mid-count -> IDLE, `counter` holds, no `tick`.
- Reset/priority: `reset`=0 asserted mid-RUN with `load`=1 and step due -> next cycle `counter`=0, IDLE, all pulses 0. `load` coincident with step -> `counter`=`load_value`, `tick`=0.
